i2s_mic_emulator: RTL
=====================

# i2s_mic_emulator

I2S microphone emulator: the transmitting end of the microphone link that the `microphones` capture block drives and samples. It follows the master's `mic_sck`/`mic_ws` and serializes queued 16-bit samples onto `mic_data` in the left slot, using the 24-bit-in-32-slot MSB-first I2S format. It serves as a loopback source for the audio → FFT → biometrics chain in simulation and on the board.

## Interface
Parameters:
- `SAMPLE_WIDTH`, default 16: width of `sample_in`; must be ≤ `DATA_BITS`.
- `SYNC_STAGES`, default 2: synchronizer flops on `mic_sck_in`/`mic_ws_in`; 0 when both come from the `clk_in` domain.

Ports:
- `clk_in`, input, 1: single clock, 98.304 MHz audio clock.
- `rst_in`, input, 1: asynchronous, active-low reset (0 = reset).
- `sample_in`, input, `SAMPLE_WIDTH`: signed two's-complement sample.
- `sample_valid_in`, input, 1: sample offered.
- `sample_ready_out`, output, 1: holding register can accept a sample.
- `mic_sck_in`, input, 1: bit clock from the I2S master.
- `mic_ws_in`, input, 1: word select from the master. Low selects the left slot, high the right slot.
- `mic_data_out`, output, 1: serial data to the master.
- `slot_start_out`, output, 1: one-cycle pulse when the left-slot word is loaded.
- `underrun_out`, output, 1: one-cycle pulse when a left slot starts with no sample available.

## Operation
- **Edge detection.** Synchronize sck and ws, then register the previous sck value. A rise is prev=0, cur=1. A fall is prev=1, cur=0.
- **Rising edge.** Capture ws into `ws_q`.
  - The first rising edge after reset only primes `ws_q`; no boundary is declared.
  - After that, `ws_q` new ≠ old is a slot boundary: `bit_idx` ← 0.
- **Left-slot load.** A boundary entering ws=0 loads the shifter from the holding register and pulses `slot_start_out`.
  - The sample is placed left-justified: shifter[23:24−SAMPLE_WIDTH] = sample, lower bits = 0.
  - If the holding register is empty and `sample_valid_in`=1 in that cycle, bypass: load `sample_in` directly; the handshake completes.
  - If the holding register is empty and no sample is offered, load 0 and pulse `underrun_out`.
- **Falling edge.**
  - If `ws_q`=0 and `bit_idx` < 24: `mic_data_out` ← shifter[23], shift left, `bit_idx`++.
  - Otherwise: `mic_data_out` ← 0, and `bit_idx` increments saturating at 31.
  - The first falling edge after a boundary therefore drives the MSB, giving the standard I2S one-bit delay after the ws change.
- **Right slot.** Always 0 (bits 24–31 of every slot are also 0; real mics tri-state there).
- **Holding register.** Single entry.
  - `sample_ready_out` = !hold_valid, driven from a register only (no combinational path from `sample_valid_in`).
  - Accept when valid && ready.
  - Load clears hold_valid; `sample_ready_out` rises the next cycle.
- **Arbitrary ws.** Early or late ws toggles (short or long slots) are tolerated: every boundary restarts `bit_idx`, and a truncated word is discarded.

## Timing
- **Reset values.** While `rst_in`=0, all state clears asynchronously:
  - `mic_data_out`=0, `slot_start_out`=0, `underrun_out`=0, `sample_ready_out`=0, hold_valid=0, bit_idx=0, primed=0.
  - `sample_ready_out` goes to 1 on the first clock edge after release.
- **Edge latency.** An sck edge on the pin is detected `SYNC_STAGES`+1 cycles later. `mic_data_out` updates 1 cycle after detection, i.e. `SYNC_STAGES`+2 cycles after the pin edge.
- **Requirement.** Half-period of sck ≥ `SYNC_STAGES`+3 clk cycles (16 cycles at the 3.072 MHz sck).
- **Pulse timing.** `slot_start_out` and `underrun_out` assert in the cycle after the rising-edge detection.
- **Reset mid-word.** The word is dropped, and output stays 0 until a new boundary is seen after priming.

## Structure
- Package `i2s_pkg` holds:
  - `SLOT_BITS`=32, `DATA_BITS`=24, `WS_LEFT`=1'b0;
  - `localparam` bit-index width `$clog2(SLOT_BITS)`.
- Sub-module `i2s_edge_tracker`, with the same clock and reset ports: synchronizer chain plus prev-register. It outputs `sck_rise`, `sck_fall` and the synced `ws`. It is reusable by `microphones`-side checkers.

## Test plan
- **Single sample.** Queue 16'hA5C3, then run sck at 16-clk half-period with 32-bit slots. The master samples 24'hA5C300 MSB-first on rising edges 2–25 after ws falls, then 0s. `slot_start_out` pulses once.
- **Streaming.** Stream 1000 random samples with valid always high. Each left word equals the next sample with no gaps; the right slot is all 0; `underrun_out` never pulses.
- **Underrun and bypass.**
  - No sample queued at a left boundary: word = 0 and `underrun_out` = 1 pulse.
  - Sample presented exactly in the load cycle: bypassed into that word, with no underrun.
- **Irregular ws.** ws toggles after 10 sck in the left slot: output truncates, and the next left slot restarts at the MSB. Negative sample 16'h8000 yields 24'h800000.
- **Mid-word reset.** Assert `rst_in` low after bit 7: `mic_data_out`=0 immediately. After release, `sample_ready_out`=1 one cycle later; the first boundary only primes; the following left boundary transmits correctly.
- **Loopback.** Connect to `microphones` with `SYNC_STAGES`=0: `audio_data` equals the queued samples in order.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared constants for the I2S microphone link: 32-bit slots carrying a
// 24-bit MSB-first word, left slot selected by ws low.
package i2s_pkg;

    localparam int   SLOT_BITS = 32;
    localparam int   DATA_BITS = 24;
    localparam logic WS_LEFT   = 1'b0;
    localparam int   IDX_W     = $clog2(SLOT_BITS);

endpackage

// File: rtl/i2s_edge_tracker.sv
// Brings the master's sck/ws into the local clock domain and produces
// registered one-cycle sck rise/fall strobes with a ws value aligned to them.
module i2s_edge_tracker #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic sck_in,
    input  logic ws_in,
    output logic sck_rise_out,
    output logic sck_fall_out,
    output logic ws_out
);

    logic sck_s;
    logic ws_s;
    logic sck_prev_q;
    logic rise_q;
    logic fall_q;
    logic ws_q;

    generate
        if (SYNC_STAGES > 0) begin : g_sync
            logic [SYNC_STAGES-1:0] sck_sync_q;
            logic [SYNC_STAGES-1:0] ws_sync_q;

            // Synchronizer chains for the asynchronous sck and ws pins
            always_ff @(posedge clk_in or negedge rst_in) begin
                if (!rst_in) begin
                    sck_sync_q <= '0;
                    ws_sync_q  <= '0;
                end else begin
                    sck_sync_q[0] <= sck_in;
                    ws_sync_q[0]  <= ws_in;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sck_sync_q[i] <= sck_sync_q[i-1];
                        ws_sync_q[i]  <= ws_sync_q[i-1];
                    end
                end
            end

            assign sck_s = sck_sync_q[SYNC_STAGES-1];
            assign ws_s  = ws_sync_q[SYNC_STAGES-1];
        end else begin : g_nosync
            assign sck_s = sck_in;
            assign ws_s  = ws_in;
        end
    endgenerate

    // Previous-sck register and registered edge strobes with aligned ws
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sck_prev_q <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            ws_q       <= 1'b0;
        end else begin
            sck_prev_q <= sck_s;
            rise_q     <= sck_s & ~sck_prev_q;
            fall_q     <= ~sck_s & sck_prev_q;
            ws_q       <= ws_s;
        end
    end

    assign sck_rise_out = rise_q;
    assign sck_fall_out = fall_q;
    assign ws_out       = ws_q;

endmodule

// File: rtl/i2s_mic_emulator.sv
// I2S microphone emulator: follows the master's sck/ws and shifts queued
// samples out MSB-first in the left slot (24 data bits in a 32-bit slot).
// The right slot and the trailing 8 bits of every slot are driven 0.
module i2s_mic_emulator #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [SAMPLE_WIDTH-1:0] sample_in,
    input  logic                    sample_valid_in,
    output logic                    sample_ready_out,
    input  logic                    mic_sck_in,
    input  logic                    mic_ws_in,
    output logic                    mic_data_out,
    output logic                    slot_start_out,
    output logic                    underrun_out
);

    import i2s_pkg::*;

    localparam logic [IDX_W-1:0] IDX_DATA = IDX_W'(DATA_BITS);
    localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(SLOT_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    // Place a sample left-justified in the 24-bit word, low bits zero.
    function automatic logic [DATA_BITS-1:0] justify(input logic [SAMPLE_WIDTH-1:0] s);
        logic [DATA_BITS-1:0] w;
        w = DATA_BITS'(s);
        return w << (DATA_BITS - SAMPLE_WIDTH);
    endfunction

    logic sck_rise_s;
    logic sck_fall_s;
    logic ws_s;
    logic accept_s;
    logic boundary_s;
    logic load_left_s;

    logic                    primed_q,     primed_d;
    logic                    ws_q,         ws_d;
    logic [IDX_W-1:0]        bit_idx_q,    bit_idx_d;
    logic [DATA_BITS-1:0]    shift_q,      shift_d;
    logic [SAMPLE_WIDTH-1:0] hold_q,       hold_d;
    logic                    hold_valid_q, hold_valid_d;
    logic                    ready_q,      ready_d;
    logic                    data_q,       data_d;
    logic                    slot_start_q, slot_start_d;
    logic                    underrun_q,   underrun_d;

    i2s_edge_tracker #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .sck_in      (mic_sck_in),
        .ws_in       (mic_ws_in),
        .sck_rise_out(sck_rise_s),
        .sck_fall_out(sck_fall_s),
        .ws_out      (ws_s)
    );

    // Next-state logic: slot tracking, serializer and single-entry holding register
    always_comb begin
        accept_s    = sample_valid_in & ready_q;
        boundary_s  = sck_rise_s & primed_q & (ws_s != ws_q);
        load_left_s = boundary_s & (ws_s == WS_LEFT);

        primed_d     = primed_q;
        ws_d         = ws_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        data_d       = data_q;
        slot_start_d = 1'b0;
        underrun_d   = 1'b0;

        if (sck_rise_s) begin
            primed_d = 1'b1;
            ws_d     = ws_s;
            if (boundary_s) begin
                bit_idx_d = '0;
            end else begin
                bit_idx_d = bit_idx_q;
            end
        end else if (sck_fall_s) begin
            if ((ws_q == WS_LEFT) && (bit_idx_q < IDX_DATA)) begin
                data_d    = shift_q[DATA_BITS-1];
                shift_d   = {shift_q[DATA_BITS-2:0], 1'b0};
                bit_idx_d = bit_idx_q + IDX_ONE;
            end else begin
                data_d = 1'b0;
                if (bit_idx_q != IDX_MAX) begin
                    bit_idx_d = bit_idx_q + IDX_ONE;
                end else begin
                    bit_idx_d = bit_idx_q;
                end
            end
        end else begin
            data_d = data_q;
        end

        // A left boundary consumes the held sample, a same-cycle offer, or zeros
        if (load_left_s) begin
            slot_start_d = 1'b1;
            if (hold_valid_q) begin
                shift_d      = justify(hold_q);
                hold_valid_d = 1'b0;
            end else if (accept_s) begin
                shift_d = justify(sample_in);
            end else begin
                shift_d    = '0;
                underrun_d = 1'b1;
            end
        end else if (accept_s) begin
            hold_d       = sample_in;
            hold_valid_d = 1'b1;
        end else begin
            hold_valid_d = hold_valid_q;
        end

        ready_d = ~hold_valid_d;
    end

    // State and registered outputs
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            primed_q     <= 1'b0;
            ws_q         <= 1'b0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            ready_q      <= 1'b0;
            data_q       <= 1'b0;
            slot_start_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            primed_q     <= primed_d;
            ws_q         <= ws_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            ready_q      <= ready_d;
            data_q       <= data_d;
            slot_start_q <= slot_start_d;
            underrun_q   <= underrun_d;
        end
    end

    assign sample_ready_out = ready_q;
    assign mic_data_out     = data_q;
    assign slot_start_out   = slot_start_q;
    assign underrun_out     = underrun_q;

endmodule
